fsm_updown_counter_n: RTL and testbench

- Parametrised successor to the team's 2-bit up/down counter FSM.
- Modulo-MOD counter, WIDTH bits wide, with enable, synchronous load, wrap or saturate mode, a terminal-count pulse and a visible FSM state.
- Used as the general-purpose sequencer/counter in the FSM library.
- Keeps the existing direction convention: dir=1 counts down, dir=0 counts up.

---
 rtl/fsm_updown_counter_n.sv | 129 ++++++++++++
 tb/tb_fsm_updown_counter_n.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_updown_counter_n.sv
// Modulo-MOD up/down counter FSM with enable, clamped synchronous load, wrap/saturate modes and a terminal-count pulse.
// Optional FSM_CNT_GRAY_OUT_EN adds a registered Gray-coded copy of z (z_gray); MOD must then be a power of two.
module fsm_updown_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MOD     = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] z,
  output logic             tc,
  output logic             sat,
`ifdef FSM_CNT_GRAY_OUT_EN
  output logic [WIDTH-1:0] z_gray,
`endif
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    SAT  = 2'b11
  } state_t;

  // Top limit held at WIDTH+1 bits so MOD == 2**WIDTH still compares correctly
  localparam logic [WIDTH:0]   LIM   = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_Z = WIDTH'(RST_VAL);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("fsm_updown_counter_n: WIDTH must be in 2..16");
  end
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("fsm_updown_counter_n: MOD must be in 2..2**WIDTH");
  end
  if (RST_VAL < 0 || RST_VAL >= MOD) begin : g_bad_rst
    $error("fsm_updown_counter_n: RST_VAL must be below MOD");
  end
`ifdef FSM_CNT_GRAY_OUT_EN
  if ((MOD & (MOD - 1)) != 0) begin : g_bad_gray
    $error("fsm_updown_counter_n: Gray output needs MOD to be a power of two");
  end
`endif

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    clamp_load = ({1'b0, v} > LIM) ? LIM[WIDTH-1:0] : v;
  endfunction

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    to_gray = b ^ (b >> 1);
  endfunction

  state_t           state, state_next;
  logic [WIDTH-1:0] z_next;
  logic             tc_next, sat_next;
  logic             at_top, at_bot;

  assign at_top    = ({1'b0, z} == LIM);
  assign at_bot    = (z == '0);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      z      <= RST_Z;
      tc     <= 1'b0;
      sat    <= 1'b0;
`ifdef FSM_CNT_GRAY_OUT_EN
      z_gray <= to_gray(RST_Z);
`endif
    end else begin
      state  <= state_next;
      z      <= z_next;
      tc     <= tc_next;
      sat    <= sat_next;
`ifdef FSM_CNT_GRAY_OUT_EN
      z_gray <= to_gray(z_next);
`endif
    end
  end

  always_comb begin
    state_next = IDLE;
    if (!load && en) begin
      if (!dir) state_next = (at_top && sat_mode) ? SAT : UP;
      else      state_next = (at_bot && sat_mode) ? SAT : DOWN;
    end
  end

  always_comb begin
    z_next   = z;
    tc_next  = 1'b0;
    sat_next = 1'b0;
    if (load) begin
      z_next = clamp_load(load_val);
    end else if (en) begin
      if (!dir) begin
        if (!at_top) begin
          z_next = z + WIDTH'(1);
        end else if (!sat_mode) begin
          z_next  = '0;
          tc_next = 1'b1;
        end else begin
          sat_next = 1'b1;
          tc_next  = (state != SAT);
        end
      end else begin
        if (!at_bot) begin
          z_next = z - WIDTH'(1);
        end else if (!sat_mode) begin
          z_next  = LIM[WIDTH-1:0];
          tc_next = 1'b1;
        end else begin
          sat_next = 1'b1;
          tc_next  = (state != SAT);
        end
      end
    end else begin
      // Idling out of SAT keeps the flag visible; any other idle clears it
      sat_next = (state == SAT) ? sat : 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_updown_counter_n.sv
// Randomized self-checking bench for fsm_updown_counter_n: two instances (MOD_A and MOD=16) against an arithmetic reference model.
module tb_fsm_updown_counter_n;
`ifdef FSM_CNT_GRAY_OUT_EN
  localparam int MOD_A = 8;
`else
  localparam int MOD_A = 10;
`endif
  localparam int MOD_B = 16;
  localparam int S_IDLE = 0, S_UP = 1, S_DOWN = 2, S_SAT = 3;

  typedef struct {
    int z;
    bit tc;
    bit sat;
    int st;
  } mstate_t;

  logic       clk, reset, en, dir, sat_mode, load;
  logic [3:0] load_val;
  logic [3:0] z_a, z_b;
  logic       tc_a, tc_b, sat_a, sat_b;
  logic [1:0] st_a, st_b;
  logic [7:0] obs_a, obs_b;
`ifdef FSM_CNT_GRAY_OUT_EN
  logic [3:0] zg_a, zg_b;
`endif

  int      n_checks = 0;
  int      n_fail   = 0;
  mstate_t m [2];
  int      mods [2];

  fsm_updown_counter_n #(.WIDTH(4), .MOD(MOD_A), .RST_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .z(z_a), .tc(tc_a), .sat(sat_a),
`ifdef FSM_CNT_GRAY_OUT_EN
    .z_gray(zg_a),
`endif
    .fsm_state(st_a)
  );

  fsm_updown_counter_n #(.WIDTH(4), .MOD(MOD_B), .RST_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .z(z_b), .tc(tc_b), .sat(sat_b),
`ifdef FSM_CNT_GRAY_OUT_EN
    .z_gray(zg_b),
`endif
    .fsm_state(st_b)
  );

  assign obs_a = {z_a, tc_a, sat_a, st_a};
  assign obs_b = {z_b, tc_b, sat_b, st_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mstate_t rst_state();
    mstate_t r;
    r.z = 0; r.tc = 0; r.sat = 0; r.st = S_IDLE;
    return r;
  endfunction

  // Reference: modular arithmetic on an integer count, saturation at the limit of travel
  function automatic mstate_t ref_step(mstate_t s, int mod, bit e, bit d, bit sm, bit l, int lv);
    mstate_t r;
    int lim;
    r = s;
    r.tc = 0;
    if (l) begin
      r.z = (lv >= mod) ? mod - 1 : lv;
      r.sat = 0;
      r.st = S_IDLE;
    end else if (e) begin
      lim = d ? 0 : mod - 1;
      if (s.z == lim && sm) begin
        r.st = S_SAT;
        r.sat = 1;
        r.tc = (s.st != S_SAT);
      end else begin
        r.z = (s.z + (d ? mod - 1 : 1)) % mod;
        r.tc = (s.z == lim);
        r.sat = 0;
        r.st = d ? S_DOWN : S_UP;
      end
    end else begin
      r.st = S_IDLE;
      r.sat = (s.st == S_SAT) && s.sat;
    end
    return r;
  endfunction

  function automatic logic [7:0] pack(mstate_t s);
    return {4'(s.z), s.tc, s.sat, 2'(s.st)};
  endfunction

  function automatic logic [3:0] gray_of(int v);
    logic [3:0] b;
    b = 4'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic tick(input bit e, input bit d, input bit s, input bit l, input int lv);
    en = e; dir = d; sat_mode = s; load = l; load_val = 4'(lv);
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = reset ? ref_step(m[i], mods[i], e, d, s, l, lv) : rst_state();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(1, 0, 0, 0, 0);
      n_checks++;
      if (obs_a !== 8'h00 || obs_b !== 8'h00) begin
        n_fail++;
        $display("FAIL reset c=%0d got a=%h b=%h want 00", c, obs_a, obs_b);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_up_wrap();
    tick(0, 0, 0, 1, 0);
    for (int c = 0; c < MOD_A; c++) begin
      tick(1, 0, 0, 0, 0);
      n_checks++;
      if (z_a !== 4'((c + 1) % MOD_A) || tc_a !== (c == MOD_A - 1) || st_a !== 2'b01 ||
          obs_b !== pack(m[1])) begin
        n_fail++;
        $display("FAIL up_wrap c=%0d got z=%0d tc=%b st=%b b=%h want z=%0d tc=%b st=01 b=%h",
                 c, z_a, tc_a, st_a, obs_b, (c + 1) % MOD_A, c == MOD_A - 1, pack(m[1]));
      end
    end
  endtask

  task automatic test_mid_reset();
    tick(0, 0, 0, 1, 8);
    tick(1, 0, 0, 0, 0);
    n_checks++;
    if (z_b !== 4'd9) begin
      n_fail++;
      $display("FAIL mid_reset_setup got z=%0d want 9", z_b);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) m[i] = rst_state();
    n_checks++;
    if (obs_a !== 8'h00 || obs_b !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset_async got a=%h b=%h want 00", obs_a, obs_b);
    end
    tick(1, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_down_sat();
    int ez [5] = '{1, 0, 0, 0, 0};
    int et [5] = '{0, 0, 1, 0, 0};
    int es [5] = '{0, 0, 1, 1, 1};
    int est [5] = '{2, 2, 3, 3, 3};
    tick(0, 0, 0, 1, 2);
    for (int c = 0; c < 5; c++) begin
      tick(1, 1, 1, 0, 0);
      n_checks++;
      if (z_b !== 4'(ez[c]) || tc_b !== 1'(et[c]) || sat_b !== 1'(es[c]) || st_b !== 2'(est[c]) ||
          obs_a !== pack(m[0])) begin
        n_fail++;
        $display("FAIL down_sat c=%0d got z=%0d tc=%b sat=%b st=%0d a=%h want z=%0d tc=%0d sat=%0d st=%0d a=%h",
                 c, z_b, tc_b, sat_b, st_b, obs_a, ez[c], et[c], es[c], est[c], pack(m[0]));
      end
    end
    tick(1, 0, 1, 0, 0);
    n_checks++;
    if (z_b !== 4'd1 || sat_b !== 1'b0 || st_b !== 2'b01 || tc_b !== 1'b0) begin
      n_fail++;
      $display("FAIL leave_sat got z=%0d sat=%b st=%b tc=%b want z=1 sat=0 st=01 tc=0", z_b, sat_b, st_b, tc_b);
    end
  endtask

  task automatic test_load_clamp();
    tick(1, 0, 0, 1, 13);
    n_checks++;
    if (z_a !== 4'(MOD_A - 1) || tc_a !== 1'b0 || st_a !== 2'b00 || z_b !== 4'd13) begin
      n_fail++;
      $display("FAIL load_clamp got za=%0d tc=%b st=%b zb=%0d want za=%0d tc=0 st=00 zb=13",
               z_a, tc_a, st_a, z_b, MOD_A - 1);
    end
    tick(1, 0, 0, 0, 0);
    n_checks++;
    if (z_a !== 4'd0 || tc_a !== 1'b1 || st_a !== 2'b01) begin
      n_fail++;
      $display("FAIL load_then_wrap got z=%0d tc=%b st=%b want z=0 tc=1 st=01", z_a, tc_a, st_a);
    end
  endtask

  task automatic test_reversal();
    int ez [4] = '{5, 6, 5, 4};
    int est [4] = '{1, 1, 2, 2};
    tick(0, 0, 0, 1, 4);
    for (int c = 0; c < 4; c++) begin
      tick(1, (c >= 2), 0, 0, 0);
      n_checks++;
      if (z_b !== 4'(ez[c]) || st_b !== 2'(est[c]) || tc_b !== 1'b0) begin
        n_fail++;
        $display("FAIL reversal c=%0d got z=%0d st=%0d tc=%b want z=%0d st=%0d tc=0",
                 c, z_b, st_b, tc_b, ez[c], est[c]);
      end
    end
  endtask

  task automatic test_random();
    bit e, d, s, l;
    int lv;
    for (int c = 0; c < 400; c++) begin
      e  = ($urandom_range(0, 7) != 0);
      d  = ($urandom_range(0, 5) == 0) ? ~dir : dir;
      s  = ($urandom_range(0, 9) == 0) ? ~sat_mode : sat_mode;
      l  = ($urandom_range(0, 19) == 0);
      lv = $urandom_range(0, 15);
      tick(e, d, s, l, lv);
      n_checks++;
      if (obs_a !== pack(m[0]) || obs_b !== pack(m[1])) begin
        n_fail++;
        $display("FAIL random c=%0d got a=%h b=%h want a=%h b=%h", c, obs_a, obs_b, pack(m[0]), pack(m[1]));
      end
`ifdef FSM_CNT_GRAY_OUT_EN
      n_checks++;
      if (zg_a !== gray_of(m[0].z) || zg_b !== gray_of(m[1].z)) begin
        n_fail++;
        $display("FAIL random_gray c=%0d got a=%b b=%b want a=%b b=%b",
                 c, zg_a, zg_b, gray_of(m[0].z), gray_of(m[1].z));
      end
`endif
    end
  endtask

`ifdef FSM_CNT_GRAY_OUT_EN
  task automatic test_gray();
    logic [3:0] eg [3] = '{4'b1001, 4'b1000, 4'b0000};
    logic [3:0] prev;
    tick(0, 0, 0, 1, 14);
    prev = zg_b;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick(1, 0, 0, 0, 0);
      n_checks++;
      if (zg_b !== eg[c] || (c > 0 && $countones(zg_b ^ prev) != 1)) begin
        n_fail++;
        $display("FAIL gray c=%0d got %b prev=%b want %b", c, zg_b, prev, eg[c]);
      end
      prev = zg_b;
    end
  endtask
`endif

  initial begin
    mods[0] = MOD_A;
    mods[1] = MOD_B;
    m[0] = rst_state();
    m[1] = rst_state();
    reset = 1'b0; en = 1'b0; dir = 1'b0; sat_mode = 1'b0; load = 1'b0; load_val = 4'd0;
    #2;
    test_reset();
    test_up_wrap();
    test_mid_reset();
    test_down_sat();
    test_load_clamp();
    test_reversal();
`ifdef FSM_CNT_GRAY_OUT_EN
    test_gray();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
